// File: rtl/vga_pkg.sv
// Shared screen geometry, ball/pad constants and FSM/direction types for the pong datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

  // Screen and object geometry; draw_ball_pads uses the same numbers.
  localparam int HOR_PIXELS  = 1024;
  localparam int VER_PIXELS  = 768;
  localparam int BALL_SIZE   = 15;
  localparam int PAD_WIDTH   = 15;
  localparam int PAD_HEIGHT  = 145;
  localparam int X_PAD_LEFT  = 30;
  localparam int X_PAD_RIGHT = 979;

  // Largest legal top-left corner of the ball bounding box.
  localparam int X_BALL_MAX = HOR_PIXELS - BALL_SIZE - 1;   // 1008
  localparam int Y_BALL_MAX = VER_PIXELS - BALL_SIZE - 1;   // 752

  // Ball rest position between rallies.
  localparam int X_BALL_CENTRE = X_BALL_MAX / 2;            // 504
  localparam int Y_BALL_CENTRE = Y_BALL_MAX / 2;            // 376

  // Pad faces seen by the ball's left column.
  localparam int X_LEFT_PAD_FACE  = X_PAD_LEFT + PAD_WIDTH; // 45, ball must stay right of this
  localparam int X_RIGHT_PAD_FACE = X_PAD_RIGHT - BALL_SIZE; // 964, ball must stay left of this

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_SCORE = 2'd3
  } ball_state_t;

  typedef enum logic {
    DX_LEFT  = 1'b0,
    DX_RIGHT = 1'b1
  } dx_t;

  typedef enum logic {
    DY_UP   = 1'b0,
    DY_DOWN = 1'b1
  } dy_t;

endpackage

// File: rtl/ball_collision.sv
// Combinational ball step: next x/y for one frame plus wall, pad and miss flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to commit the result.
module ball_collision
  import vga_pkg::*;
#(
  parameter int BALL_SPEED = 4
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  dx_t        dx,
  input  dy_t        dy,
  input  logic [9:0] y_pad_left,
  input  logic [9:0] y_pad_right,
  output logic [9:0] x_next,
  output logic [9:0] y_next,
  output logic       hit_top,
  output logic       hit_bottom,
  output logic       hit_pad_left,
  output logic       hit_pad_right,
  output logic       miss_left,
  output logic       miss_right
);

  // Everything is compared at 11 bits so pad_top+height and x+speed cannot wrap.
  localparam logic [10:0] SPD        = 11'(BALL_SPEED);
  localparam logic [10:0] X_MAX      = 11'(X_BALL_MAX);
  localparam logic [10:0] Y_MAX      = 11'(Y_BALL_MAX);
  localparam logic [10:0] BALL_H     = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_H      = 11'(PAD_HEIGHT);
  localparam logic [10:0] L_FACE     = 11'(X_LEFT_PAD_FACE);
  localparam logic [10:0] R_FACE     = 11'(X_RIGHT_PAD_FACE);
  localparam logic [10:0] L_REBOUND  = L_FACE + 11'd1;
  localparam logic [10:0] R_REBOUND  = R_FACE - 11'd1;

  logic [10:0] x11;
  logic [10:0] y11;
  logic [10:0] pl11;
  logic [10:0] pr11;
  logic        span_left;
  logic        span_right;

  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign pl11 = {1'b0, y_pad_left};
  assign pr11 = {1'b0, y_pad_right};

  // Vertical overlap of the ball box with each pad, judged on the pre-move row.
  assign span_left  = ((y11 + BALL_H) >= pl11) && (y11 <= (pl11 + PAD_H));
  assign span_right = ((y11 + BALL_H) >= pr11) && (y11 <= (pr11 + PAD_H));

  // Vertical and horizontal moves are independent so a corner bounce applies both.
  always_comb begin
    x_next        = x;
    y_next        = y;
    hit_top       = 1'b0;
    hit_bottom    = 1'b0;
    hit_pad_left  = 1'b0;
    hit_pad_right = 1'b0;
    miss_left     = 1'b0;
    miss_right    = 1'b0;

    if (dy == DY_UP) begin
      if (y11 < SPD) begin
        hit_top = 1'b1;
        y_next  = '0;
      end else begin
        y_next = 10'(y11 - SPD);
      end
    end else begin
      if ((y11 + SPD) > Y_MAX) begin
        hit_bottom = 1'b1;
        y_next     = 10'(Y_MAX);
      end else begin
        y_next = 10'(y11 + SPD);
      end
    end

    // A pad hit is checked before the miss so a ball grazing the pad is returned.
    if (dx == DX_LEFT) begin
      if ((x11 > L_FACE) && (x11 <= (L_FACE + SPD)) && span_left) begin
        hit_pad_left = 1'b1;
        x_next       = 10'(L_REBOUND);
      end else if (x11 < SPD) begin
        miss_left = 1'b1;
      end else begin
        x_next = 10'(x11 - SPD);
      end
    end else begin
      if ((x11 < R_FACE) && ((x11 + SPD) >= R_FACE) && span_right) begin
        hit_pad_right = 1'b1;
        x_next        = 10'(R_REBOUND);
      end else if ((x11 + SPD) > X_MAX) begin
        miss_right = 1'b1;
      end else begin
        x_next = 10'(x11 + SPD);
      end
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Pong ball FSM: serve hold, per-frame motion, bounces and scoring pulses.
// Latency: position/score update visible one clk after the frame_tick that causes it.
// Backpressure: none; stop forces IDLE, start and frame_tick are ignored where meaningless.
module ball_controller
  import vga_pkg::*;
#(
  parameter int BALL_SPEED   = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       stop,
  input  logic [9:0] y_pad_left,
  input  logic [9:0] y_pad_right,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic       score_left,
  output logic       score_right,
  output logic       ball_active
);

  localparam int               CNT_W    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [9:0]       X_CTR    = 10'(X_BALL_CENTRE);
  localparam logic [9:0]       Y_CTR    = 10'(Y_BALL_CENTRE);

  ball_state_t      state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  dx_t              dx_q, dx_d;
  dy_t              dy_q, dy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             score_left_q, score_left_d;
  logic             score_right_q, score_right_d;

  logic [9:0] col_x;
  logic [9:0] col_y;
  logic       hit_top;
  logic       hit_bottom;
  logic       hit_pad_left;
  logic       hit_pad_right;
  logic       miss_left;
  logic       miss_right;

  ball_collision #(
    .BALL_SPEED (BALL_SPEED)
  ) u_collision (
    .x             (x_q),
    .y             (y_q),
    .dx            (dx_q),
    .dy            (dy_q),
    .y_pad_left    (y_pad_left),
    .y_pad_right   (y_pad_right),
    .x_next        (col_x),
    .y_next        (col_y),
    .hit_top       (hit_top),
    .hit_bottom    (hit_bottom),
    .hit_pad_left  (hit_pad_left),
    .hit_pad_right (hit_pad_right),
    .miss_left     (miss_left),
    .miss_right    (miss_right)
  );

  // State, ball kinematics, serve counter and the registered score pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      x_q           <= X_CTR;
      y_q           <= Y_CTR;
      dx_q          <= DX_RIGHT;
      dy_q          <= DY_DOWN;
      cnt_q         <= '0;
      score_left_q  <= 1'b0;
      score_right_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      cnt_q         <= cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
    end
  end

  // Next-state logic; stop wins over everything and never produces a score pulse.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    cnt_d         = cnt_q;
    score_left_d  = 1'b0;
    score_right_d = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      x_d     = X_CTR;
      y_d     = Y_CTR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          x_d = X_CTR;
          y_d = Y_CTR;
          if (start) begin
            state_d = ST_SERVE;
            dx_d    = DX_RIGHT;
            dy_d    = DY_DOWN;
            cnt_d   = '0;
          end
        end

        ST_SERVE: begin
          x_d = X_CTR;
          y_d = Y_CTR;
          if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_MOVE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_MOVE: begin
          if (frame_tick) begin
            x_d = col_x;
            y_d = col_y;
            if (hit_top) begin
              dy_d = DY_DOWN;
            end else if (hit_bottom) begin
              dy_d = DY_UP;
            end
            if (hit_pad_left) begin
              dx_d = DX_RIGHT;
            end else if (hit_pad_right) begin
              dx_d = DX_LEFT;
            end
            // A miss recentres straight away and serves towards the player who lost the point.
            if (miss_left) begin
              state_d       = ST_SCORE;
              score_right_d = 1'b1;
              x_d           = X_CTR;
              y_d           = Y_CTR;
              dx_d          = DX_LEFT;
            end else if (miss_right) begin
              state_d      = ST_SCORE;
              score_left_d = 1'b1;
              x_d          = X_CTR;
              y_d          = Y_CTR;
              dx_d         = DX_RIGHT;
            end
          end
        end

        ST_SCORE: begin
          state_d = ST_SERVE;
          x_d     = X_CTR;
          y_d     = Y_CTR;
          cnt_d   = '0;
        end

        default: begin
          state_d = ST_IDLE;
          x_d     = X_CTR;
          y_d     = Y_CTR;
        end
      endcase
    end
  end

  assign x_ball      = x_q;
  assign y_ball      = y_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign ball_active = (state_q == ST_MOVE);

endmodule

// File: tb/tb_ball_controller.sv
// Randomised scoreboard bench for ball_controller against a behavioural pong model.
// Latency: expectations are queued one cycle ahead and checked 1 time unit after each clk edge.
// Backpressure: none; the monitor only pops when an expectation is pending.
module tb_ball_controller;

  localparam int SPEED   = 4;
  localparam int SERVE   = 60;
  localparam int NCYCLES = 40000;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_MOVE  = 2;
  localparam int M_SCORE = 3;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       stop;
  logic [9:0] y_pad_left;
  logic [9:0] y_pad_right;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic       score_left;
  logic       score_right;
  logic       ball_active;

  ball_controller #(
    .BALL_SPEED   (SPEED),
    .SERVE_FRAMES (SERVE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .stop        (stop),
    .y_pad_left  (y_pad_left),
    .y_pad_right (y_pad_right),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .score_left  (score_left),
    .score_right (score_right),
    .ball_active (ball_active)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       sl;
    logic       sr;
    logic       act;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural model: signed positions and unit velocities, frames counted up to SERVE.
  int m_mode, m_x, m_y, m_vx, m_vy, m_frames;
  bit m_sl, m_sr;
  int n_hits, n_scores;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t sample();
    obs_t o;
    o.x   = x_ball;
    o.y   = y_ball;
    o.sl  = score_left;
    o.sr  = score_right;
    o.act = ball_active;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.x   = 10'(m_x);
    o.y   = 10'(m_y);
    o.sl  = m_sl;
    o.sr  = m_sr;
    o.act = (m_mode == M_MOVE);
    return o;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got x=%0d y=%0d sl=%0b sr=%0b act=%0b, expected x=%0d y=%0d sl=%0b sr=%0b act=%0b",
               name, $time, got.x, got.y, got.sl, got.sr, got.act,
               want.x, want.y, want.sl, want.sr, want.act);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 504; m_y = 376; m_vx = 1; m_vy = 1; m_frames = 0;
    m_sl = 0; m_sr = 0;
  endtask

  task automatic model_move(input int pl, input int pr);
    int  nx, ny;
    bit  on_l, on_r;
    ny = m_y + SPEED * m_vy;
    if (ny < 0) begin ny = 0; m_vy = 1; end
    else if (ny > 752) begin ny = 752; m_vy = -1; end
    on_l = (m_y + 15 >= pl) && (m_y <= pl + 145);
    on_r = (m_y + 15 >= pr) && (m_y <= pr + 145);
    nx = m_x + SPEED * m_vx;
    if (m_vx < 0 && m_x > 45 && nx <= 45 && on_l) begin
      nx = 46; m_vx = 1; n_hits++;
    end else if (m_vx > 0 && m_x < 964 && nx >= 964 && on_r) begin
      nx = 963; m_vx = -1; n_hits++;
    end else if (nx < 0) begin
      m_sr = 1; m_mode = M_SCORE; m_vx = -1; n_scores++;
    end else if (nx > 1008) begin
      m_sl = 1; m_mode = M_SCORE; m_vx = 1; n_scores++;
    end
    if (m_mode == M_SCORE) begin
      m_x = 504; m_y = 376;
    end else begin
      m_x = nx; m_y = ny;
    end
  endtask

  task automatic model_step(input bit tk, input bit st, input bit sp, input int pl, input int pr);
    m_sl = 0; m_sr = 0;
    if (sp) begin
      m_mode = M_IDLE; m_x = 504; m_y = 376;
    end else begin
      case (m_mode)
        M_IDLE:  if (st) begin m_mode = M_SERVE; m_vx = 1; m_vy = 1; m_frames = 0; end
        M_SERVE: if (tk) begin
                   m_frames++;
                   if (m_frames == SERVE) m_mode = M_MOVE;
                 end
        M_MOVE:  if (tk) model_move(pl, pr);
        default: begin m_mode = M_SERVE; m_frames = 0; end
      endcase
    end
  endtask

  // Pad placement biased around the ball row, including the exact overlap edges.
  function automatic int pick_pad(input int y);
    int r, p;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: p = y - int'($urandom_range(0, 145));
      4:          p = y + 15;
      5:          p = y + 16;
      6:          p = y - 145;
      7:          p = y - 146;
      default:    p = int'($urandom_range(0, 1023));
    endcase
    if (p < 0 || p > 1023) p = int'($urandom_range(0, 1023));
    return p;
  endfunction

  task automatic do_async_reset();
    obs_t want;
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
    #1;
    model_reset();
    want = model_obs();
    compare("async_reset", sample(), want);
    exp_q.push_back(want);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Monitor: one queued expectation per clock edge.
  initial begin
    obs_t want;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        compare("scoreboard", sample(), want);
      end
    end
  end

  // Stimulus: random inputs, model stepped with exactly what the DUT will sample.
  initial begin
    bit tk, st, sp, prev_tk, rst_pending, did_stop_start;
    int pl, pr, rst_count;
    obs_t want;
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
    y_pad_left = '0; y_pad_right = '0;
    n_hits = 0; n_scores = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    compare("reset_state", sample(), model_obs());
    @(posedge clk); #2;
    rst = 1'b0;

    prev_tk = 0; rst_pending = 0; rst_count = 0; did_stop_start = 0;
    for (int i = 0; i < NCYCLES; i++) begin
      if (i % 9000 == 8999) rst_pending = 1;
      if (rst_pending && (((rst_count % 2 == 0) && m_mode == M_SERVE && m_frames > 5) ||
                          ((rst_count % 2 == 1) && m_mode == M_MOVE))) begin
        do_async_reset();
        rst_pending = 0;
        rst_count++;
        prev_tk = 0;
      end

      tk = !prev_tk && ($urandom_range(0, 2) == 0);
      st = (i == 0) || ($urandom_range(0, 39) == 0);
      sp = (i > 400) && ($urandom_range(0, 1499) == 0);
      if (sp) st = $urandom_range(0, 1);
      if (!did_stop_start && i > 20000 && m_mode == M_MOVE) begin
        sp = 1; st = 1; did_stop_start = 1;
      end
      pl = pick_pad(m_y);
      pr = pick_pad(m_y);

      frame_tick  = tk;
      start       = st;
      stop        = sp;
      y_pad_left  = 10'(pl);
      y_pad_right = 10'(pr);
      prev_tk     = tk;

      model_step(tk, st, sp, pl, pr);
      want = model_obs();
      exp_q.push_back(want);

      @(posedge clk); #2;
    end

    frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("pad hits %0d, points scored %0d", n_hits, n_scores);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
